// File: rtl/ps2_lane_decoder.sv
// PS/2 device-to-host deframer with E0/F0 prefix handling and per-lane held/released tracking.
// Optional odd-parity checking is enabled by defining PS2_PARITY_CHECK_EN.

module ps2_lane_cell #(
    parameter logic [7:0] CODE = 8'h00
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       fire,
    input  logic       ext,
    input  logic       brk,
    input  logic [7:0] byte_in,
    output logic       held,
    output logic       press,
    output logic       rel
);
    logic hit;
    assign hit = fire && !ext && (byte_in == CODE);

    always_ff @(posedge clk_in) begin
        if (!rst) begin
            held  <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            // typematic repeats and stray breaks fall through without a pulse
            press <= hit && !brk && !held;
            rel   <= hit && brk && held;
            if (hit) held <= !brk;
        end
    end
endmodule

module ps2_lane_decoder #(
    parameter int          NUM_LANES   = 4,
    parameter logic [63:0] LANE_CODES  = 64'h0000_0000_423B_2B23,
    parameter int          SYNC_STAGES = 2,
    parameter int          TIMEOUT_CYC = 50000
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 key_clk,
    input  logic                 key_data,
    output logic [NUM_LANES-1:0] lane_state,
    output logic [NUM_LANES-1:0] lane_press,
    output logic [NUM_LANES-1:0] lane_release,
    output logic                 code_valid,
    output logic [7:0]           code_byte,
    output logic                 code_ext,
    output logic                 code_break,
    output logic                 frame_err
);
    localparam int WD_W = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
    logic                   clk_prev;
    logic                   fall, bit_in, timeout;

    always_ff @(posedge clk_in) begin
        if (!rst) begin
            clk_sync <= '1;
            dat_sync <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], key_clk};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], key_data};
            clk_prev <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign fall   = clk_prev && !clk_sync[SYNC_STAGES-1];
    assign bit_in = dat_sync[SYNC_STAGES-1];

    state_t      state, state_n;
    logic [2:0]  bit_cnt, bit_cnt_n;
    logic [7:0]  shreg, shreg_n;
    logic [WD_W-1:0] wd_cnt;
    logic        byte_ok, err, code_fire;
    logic        ext_flag, brk_flag;
`ifdef PS2_PARITY_CHECK_EN
    logic        par, par_n;
`endif

    // terminal count wins over a coincident key_clk edge
    assign timeout = (state != IDLE) && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_in) begin
        if (!rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            wd_cnt  <= '0;
`ifdef PS2_PARITY_CHECK_EN
            par     <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            shreg   <= shreg_n;
`ifdef PS2_PARITY_CHECK_EN
            par     <= par_n;
`endif
            if (state == IDLE || fall || timeout) wd_cnt <= '0;
            else                                  wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
`ifdef PS2_PARITY_CHECK_EN
        par_n     = par;
`endif
        byte_ok   = 1'b0;
        err       = 1'b0;
        if (timeout) begin
            state_n = IDLE;
            err     = 1'b1;
        end else if (fall) begin
            case (state)
                IDLE: if (!bit_in) begin
                    state_n   = DATA;
                    bit_cnt_n = '0;
                end
                DATA: begin
                    shreg_n   = {bit_in, shreg[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_n = PARITY;
                end
                PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                    par_n   = bit_in;
`endif
                    state_n = STOP;
                end
                STOP: begin
                    state_n = IDLE;
                    if (!bit_in) err = 1'b1;
`ifdef PS2_PARITY_CHECK_EN
                    else if (!(^{par, shreg})) err = 1'b1;
`endif
                    else byte_ok = 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign code_fire = byte_ok && (shreg != 8'hE0) && (shreg != 8'hF0);

    always_ff @(posedge clk_in) begin
        if (!rst) begin
            ext_flag   <= 1'b0;
            brk_flag   <= 1'b0;
            code_valid <= 1'b0;
            code_byte  <= 8'h00;
            code_ext   <= 1'b0;
            code_break <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            code_valid <= code_fire;
            frame_err  <= err;
            if (err) begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end else if (byte_ok) begin
                if (shreg == 8'hE0)      ext_flag <= 1'b1;
                else if (shreg == 8'hF0) brk_flag <= 1'b1;
                else begin
                    code_byte  <= shreg;
                    code_ext   <= ext_flag;
                    code_break <= brk_flag;
                    ext_flag   <= 1'b0;
                    brk_flag   <= 1'b0;
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        ps2_lane_cell #(.CODE(LANE_CODES[8*i +: 8])) u_cell (
            .clk_in (clk_in),
            .rst    (rst),
            .fire   (code_fire),
            .ext    (ext_flag),
            .brk    (brk_flag),
            .byte_in(shreg),
            .held   (lane_state[i]),
            .press  (lane_press[i]),
            .rel    (lane_release[i])
        );
    end
endmodule

// File: tb/tb_ps2_lane_decoder.sv
// Bench for ps2_lane_decoder: directed scenarios plus randomized frames against a scancode-level model.
module tb_ps2_lane_decoder;
    localparam int          NL    = 4;
    localparam logic [63:0] CODES = 64'h0000_0000_423B_2B23;
    localparam int          TO    = 400;
    localparam int          HALF  = 20;
`ifdef PS2_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic          clk_in = 1'b0, rst = 1'b0, key_clk = 1'b1, key_data = 1'b1;
    logic [NL-1:0] lane_state, lane_press, lane_release;
    logic          code_valid, code_ext, code_break, frame_err;
    logic [7:0]    code_byte;

    ps2_lane_decoder #(.NUM_LANES(NL), .LANE_CODES(CODES), .SYNC_STAGES(2), .TIMEOUT_CYC(TO)) dut (
        .clk_in(clk_in), .rst(rst), .key_clk(key_clk), .key_data(key_data),
        .lane_state(lane_state), .lane_press(lane_press), .lane_release(lane_release),
        .code_valid(code_valid), .code_byte(code_byte), .code_ext(code_ext),
        .code_break(code_break), .frame_err(frame_err)
    );

    always #10 clk_in = ~clk_in;

    int checks = 0, errors = 0;

    // observed activity, accumulated every cycle
    int       n_code = 0, n_err = 0;
    int       n_press [NL];
    int       n_rel   [NL];
    logic [7:0] got_byte = 8'h00;
    logic       got_ext = 1'b0, got_brk = 1'b0;

    initial for (int i = 0; i < NL; i++) begin n_press[i] = 0; n_rel[i] = 0; end

    always @(negedge clk_in) begin
        if (code_valid) begin
            n_code   <= n_code + 1;
            got_byte <= code_byte;
            got_ext  <= code_ext;
            got_brk  <= code_break;
        end
        if (frame_err) n_err <= n_err + 1;
        for (int i = 0; i < NL; i++) begin
            n_press[i] <= n_press[i] + int'(lane_press[i]);
            n_rel[i]   <= n_rel[i] + int'(lane_release[i]);
        end
    end

    // scancode-level reference model
    int         exp_code = 0, exp_err = 0;
    int         exp_press [NL];
    int         exp_rel   [NL];
    logic [7:0] exp_byte = 8'h00;
    logic       exp_ext = 1'b0, exp_brk = 1'b0, m_ext = 1'b0, m_brk = 1'b0;
    logic [NL-1:0] m_state = '0;

    initial for (int i = 0; i < NL; i++) begin exp_press[i] = 0; exp_rel[i] = 0; end

    task automatic model_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok);
        logic [63:0] codes;
        codes = CODES;
        if (!stop_ok || (PAR_EN && !par_ok)) begin
            exp_err++; m_ext = 1'b0; m_brk = 1'b0;
        end else if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            exp_code++; exp_byte = b; exp_ext = m_ext; exp_brk = m_brk;
            if (!m_ext)
                for (int i = 0; i < NL; i++)
                    if (codes[8*i +: 8] == b) begin
                        if (!m_brk && !m_state[i]) begin m_state[i] = 1'b1; exp_press[i]++; end
                        if (m_brk && m_state[i])   begin m_state[i] = 1'b0; exp_rel[i]++;   end
                    end
            m_ext = 1'b0; m_brk = 1'b0;
        end
    endtask

    task automatic ps2_bit(input logic v);
        key_data = v;
        repeat (HALF) @(posedge clk_in);
        key_clk = 1'b0;
        repeat (HALF) @(posedge clk_in);
        key_clk = 1'b1;
    endtask

    task automatic do_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(~^b ^ !par_ok);
        ps2_bit(stop_ok);
        key_data = 1'b1;
        repeat (40) @(posedge clk_in);
        @(negedge clk_in);
        model_frame(b, stop_ok, par_ok);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        checks++; if (lane_state !== '0)  begin errors++; $display("FAIL reset_lane_state: got %b want 0", lane_state); end
        checks++; if (code_byte !== 8'h00) begin errors++; $display("FAIL reset_code_byte: got %h want 00", code_byte); end
        checks++; if ({code_valid, code_ext, code_break, frame_err} !== 4'b0)
            begin errors++; $display("FAIL reset_flags: got %b want 0000", {code_valid, code_ext, code_break, frame_err}); end
        rst = 1'b1;
        repeat (5) @(posedge clk_in);
    endtask

    task automatic test_press_release;
        do_frame(8'h23, 1, 1);
        checks++; if (n_code !== exp_code || got_byte !== 8'h23 || got_brk !== 1'b0)
            begin errors++; $display("FAIL make_23: n=%0d byte=%h brk=%b want n=%0d byte=23 brk=0", n_code, got_byte, got_brk, exp_code); end
        checks++; if (lane_state !== 4'b0001 || n_press[0] !== exp_press[0])
            begin errors++; $display("FAIL press_23: state=%b presses=%0d want 0001/%0d", lane_state, n_press[0], exp_press[0]); end
        do_frame(8'hF0, 1, 1);
        do_frame(8'h23, 1, 1);
        checks++; if (got_brk !== 1'b1 || got_byte !== 8'h23 || n_code !== exp_code)
            begin errors++; $display("FAIL break_23: brk=%b byte=%h n=%0d want 1/23/%0d", got_brk, got_byte, n_code, exp_code); end
        checks++; if (lane_state !== 4'b0000 || n_rel[0] !== exp_rel[0])
            begin errors++; $display("FAIL release_23: state=%b rels=%0d want 0000/%0d", lane_state, n_rel[0], exp_rel[0]); end
    endtask

    task automatic test_chord;
        do_frame(8'h2B, 1, 1);
        do_frame(8'h3B, 1, 1);
        checks++; if (lane_state !== 4'b0110) begin errors++; $display("FAIL chord_state: got %b want 0110", lane_state); end
        repeat (3) do_frame(8'h2B, 1, 1);
        checks++; if (n_press[1] !== exp_press[1] || exp_press[1] !== 1)
            begin errors++; $display("FAIL typematic_press: got %0d want %0d", n_press[1], exp_press[1]); end
        do_frame(8'hF0, 1, 1);
        do_frame(8'h2B, 1, 1);
        checks++; if (lane_state !== 4'b0100) begin errors++; $display("FAIL chord_release: got %b want 0100", lane_state); end
    endtask

    task automatic test_extended;
        do_frame(8'hE0, 1, 1);
        do_frame(8'h23, 1, 1);
        checks++; if (got_ext !== 1'b1 || got_byte !== 8'h23 || n_code !== exp_code)
            begin errors++; $display("FAIL ext_code: ext=%b byte=%h n=%0d want 1/23/%0d", got_ext, got_byte, n_code, exp_code); end
        checks++; if (lane_state !== m_state) begin errors++; $display("FAIL ext_no_lane: got %b want %b", lane_state, m_state); end
    endtask

    task automatic test_timeout;
        do_frame(8'hF0, 1, 1);
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        key_data = 1'b1;
        repeat (TO + 100) @(posedge clk_in);
        @(negedge clk_in);
        exp_err++; m_ext = 1'b0; m_brk = 1'b0;
        checks++; if (n_err !== exp_err) begin errors++; $display("FAIL timeout_err: got %0d want %0d", n_err, exp_err); end
        do_frame(8'h42, 1, 1);
        checks++; if (lane_state[3] !== 1'b1 || n_press[3] !== exp_press[3] || got_brk !== 1'b0)
            begin errors++; $display("FAIL after_timeout: state=%b presses=%0d brk=%b want lane3 set/%0d/0", lane_state, n_press[3], got_brk, exp_press[3]); end
    endtask

    task automatic test_frame_errors;
        int codes_before;
        codes_before = n_code;
        do_frame(8'h3B, 0, 1);
        checks++; if (n_err !== exp_err || n_code !== codes_before)
            begin errors++; $display("FAIL stop_err: errs=%0d codes=%0d want %0d/%0d", n_err, n_code, exp_err, codes_before); end
        do_frame(8'hF0, 1, 1);
        do_frame(8'h3B, 1, 0);
        checks++; if (n_err !== exp_err || n_code !== exp_code || lane_state !== m_state)
            begin errors++; $display("FAIL parity: errs=%0d codes=%0d state=%b want %0d/%0d/%b", n_err, n_code, lane_state, exp_err, exp_code, m_state); end
    endtask

    task automatic test_reset_midframe;
        do_frame(8'h23, 1, 1);
        checks++; if (lane_state[0] !== 1'b1) begin errors++; $display("FAIL pre_reset_hold: got %b want lane0 set", lane_state); end
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        @(negedge clk_in);
        rst = 1'b0;
        @(posedge clk_in);
        @(negedge clk_in);
        checks++; if (lane_state !== '0 || code_byte !== 8'h00 || {code_valid, code_ext, code_break, frame_err} !== 4'b0)
            begin errors++; $display("FAIL midframe_reset: state=%b byte=%h flags=%b want 0/00/0000", lane_state, code_byte, {code_valid, code_ext, code_break, frame_err}); end
        rst = 1'b1;
        key_data = 1'b1;
        m_state = '0; m_ext = 1'b0; m_brk = 1'b0;
        repeat (TO + 50) @(posedge clk_in);
        do_frame(8'h23, 1, 1);
        checks++; if (lane_state !== 4'b0001 || n_press[0] !== exp_press[0] || n_err !== exp_err)
            begin errors++; $display("FAIL post_reset_press: state=%b presses=%0d errs=%0d want 0001/%0d/%0d", lane_state, n_press[0], n_err, exp_press[0], exp_err); end
    endtask

    task automatic test_random;
        logic [7:0] b;
        bit stop_ok, par_ok;
        logic [63:0] codes;
        codes = CODES;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: b = codes[8*$urandom_range(0, NL-1) +: 8];
                4:          b = 8'hE0;
                5:          b = 8'hF0;
                default:    b = 8'($urandom);
            endcase
            stop_ok = ($urandom_range(0, 9) != 0);
            par_ok  = ($urandom_range(0, 9) != 0);
            do_frame(b, stop_ok, par_ok);
            checks++; if (n_code !== exp_code || n_err !== exp_err)
                begin errors++; $display("FAIL rand_counts[%0d]: codes=%0d errs=%0d want %0d/%0d", n, n_code, n_err, exp_code, exp_err); end
            checks++; if (lane_state !== m_state)
                begin errors++; $display("FAIL rand_state[%0d]: got %b want %b", n, lane_state, m_state); end
            checks++; if ({got_byte, got_ext, got_brk} !== {exp_byte, exp_ext, exp_brk})
                begin errors++; $display("FAIL rand_code[%0d]: got %h/%b/%b want %h/%b/%b", n, got_byte, got_ext, got_brk, exp_byte, exp_ext, exp_brk); end
        end
        for (int i = 0; i < NL; i++) begin
            checks++; if (n_press[i] !== exp_press[i] || n_rel[i] !== exp_rel[i])
                begin errors++; $display("FAIL rand_pulses[%0d]: press=%0d rel=%0d want %0d/%0d", i, n_press[i], n_rel[i], exp_press[i], exp_rel[i]); end
        end
    endtask

    initial begin
        test_reset;
        test_press_release;
        test_chord;
        test_extended;
        test_timeout;
        test_frame_errors;
        test_reset_midframe;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
